plic_ctrl: RTL and testbench



---
 rtl/plic_ctrl.sv | 124 ++++++++++++
 tb/tb_plic_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_ctrl.sv
// Interrupt controller: synchronised sources, edge/level gateways, lowest-index selection and a
// single in-service claim/complete handshake on a small register bus.
module plic_ctrl #(
  parameter int MUN = 4,
  parameter int IDW = $clog2(MUN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [MUN-1:0] irq_src_i,
  input  logic           req_i,
  input  logic           we_i,
  input  logic [7:0]     addr_i,
  input  logic [31:0]    wdata_i,
  output logic [31:0]    rdata_o,
  output logic           irq_o,
  output logic [IDW-1:0] irq_id_o
);

  typedef enum logic {StIdle, StService} state_e;

  state_e         state_q, state_d;
  logic [MUN-1:0] s1_q, s2_q, s3_q;
  logic [MUN-1:0] pending_q, pending_d;
  logic [MUN-1:0] enable_q, trigger_q;
  logic [IDW-1:0] isid_q, isid_d;
  logic [IDW-1:0] sel_id;
  logic [1:0]     reg_sel;
  logic           busy, do_claim, do_complete;
  logic           unused_bits;

  assign reg_sel     = addr_i[3:2];
  assign busy        = (state_q == StService);
  assign unused_bits = ^{addr_i[7:4], addr_i[1:0], wdata_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_src_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    sel_id = '0;
    for (int i = MUN - 1; i >= 0; i--) begin
      if (pending_q[i] && enable_q[i]) sel_id = IDW'(i + 1);
    end
  end

  assign do_claim    = req_i & ~we_i & (reg_sel == 2'd3) & ~busy & (sel_id != '0);
  assign do_complete = req_i & we_i & (reg_sel == 2'd3) & busy & (wdata_i[IDW-1:0] == isid_q);

  always_comb begin
    state_d = state_q;
    isid_d  = isid_q;
    unique case (state_q)
      StIdle: begin
        if (do_claim) begin
          state_d = StService;
          isid_d  = sel_id;
        end
      end
      StService: begin
        if (do_complete) begin
          state_d = StIdle;
          isid_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Level gating looks at the post-edge service state: a claim suppresses re-set of its own
  // source, while a complete lets a still-high level source re-pend on the same edge.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < MUN; i++) begin
      if (do_claim && (sel_id == IDW'(i + 1))) pending_d[i] = 1'b0;
      if (trigger_q[i]) begin
        if (s2_q[i] && !s3_q[i]) pending_d[i] = 1'b1;
      end else if (s2_q[i] && !((state_d == StService) && (isid_d == IDW'(i + 1)))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      isid_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      trigger_q <= '0;
    end else begin
      state_q   <= state_d;
      isid_q    <= isid_d;
      pending_q <= pending_d;
      if (req_i && we_i && (reg_sel == 2'd1)) enable_q <= wdata_i[MUN-1:0];
      if (req_i && we_i && (reg_sel == 2'd2)) trigger_q <= wdata_i[MUN-1:0];
    end
  end

  always_comb begin
    rdata_o = '0;
    if (req_i) begin
      unique case (reg_sel)
        2'd0: rdata_o[MUN-1:0] = pending_q;
        2'd1: rdata_o[MUN-1:0] = enable_q;
        2'd2: rdata_o[MUN-1:0] = trigger_q;
        2'd3: rdata_o[IDW-1:0] = busy ? '0 : sel_id;
        default: ;
      endcase
    end
  end

  assign irq_o    = (sel_id != '0) & ~busy;
  assign irq_id_o = sel_id;

endmodule

// File: tb/tb_plic_ctrl.sv
// Bench for plic_ctrl: directed scenarios plus a randomized run against a cycle-level
// behavioural model of pending bits, enables, triggers and the single in-service slot.
module tb_plic_ctrl;
  localparam int MUN = 4;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [MUN-1:0] src = '0;
  logic           req = 1'b0;
  logic           we = 1'b0;
  logic [7:0]     addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic           irq;
  logic [IDW-1:0] irq_id;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  plic_ctrl #(.MUN(MUN), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src_i(src),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .irq_o    (irq),
    .irq_id_o (irq_id)
  );

  // Model: source values seen 1/2/3 edges ago, plus architectural state.
  logic [MUN-1:0] h1, h2, h3, m_pend, m_en, m_trig;
  logic           m_busy;
  logic [IDW-1:0] m_isid;

  function automatic logic [IDW-1:0] m_id();
    for (int i = 0; i < MUN; i++) if (m_pend[i] && m_en[i]) return IDW'(i + 1);
    return '0;
  endfunction

  function automatic logic m_irq();
    return (m_id() != 0) && !m_busy;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!req) return 32'd0;
    case (addr[3:2])
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_en);
      2'd2:    return 32'(m_trig);
      default: return m_busy ? 32'd0 : 32'(m_id());
    endcase
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_pend = '0; m_en = '0; m_trig = '0;
    m_busy = 1'b0; m_isid = '0;
  endtask

  task automatic tick();
    logic [IDW-1:0] id, nisid;
    logic           claim, cmpl, nbusy;
    logic [MUN-1:0] npend, nen, ntrig;
    id    = m_id();
    claim = req && !we && (addr[3:2] == 2'd3) && !m_busy && (id != 0);
    cmpl  = req && we && (addr[3:2] == 2'd3) && m_busy && (wdata[IDW-1:0] == m_isid);
    nbusy = m_busy;
    nisid = m_isid;
    if (claim) begin nbusy = 1'b1; nisid = id; end
    if (cmpl) begin nbusy = 1'b0; nisid = '0; end
    npend = m_pend;
    if (claim) npend[id-1] = 1'b0;
    for (int i = 0; i < MUN; i++) begin
      if (m_trig[i]) begin
        if (h2[i] && !h3[i]) npend[i] = 1'b1;
      end else if (h2[i] && !(nbusy && nisid == IDW'(i + 1))) begin
        npend[i] = 1'b1;
      end
    end
    nen   = (req && we && addr[3:2] == 2'd1) ? wdata[MUN-1:0] : m_en;
    ntrig = (req && we && addr[3:2] == 2'd2) ? wdata[MUN-1:0] : m_trig;
    @(posedge clk);
    m_busy = nbusy; m_isid = nisid; m_pend = npend; m_en = nen; m_trig = ntrig;
    h3 = h2; h2 = h1; h1 = src;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    tick();
    req = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (irq_id !== '0) begin bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    for (int a = 0; a < 4; a++) begin
      rd(8'(a * 4), d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
    end
  endtask

  task automatic test_edge_basic();
    logic [31:0] d;
    wr(8'h04, 32'hF);
    wr(8'h08, 32'hF);
    src[2] = 1'b1;
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_early got=%b exp=0", irq); end
    tick();
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd3) begin
      bad++; $display("FAIL edge_req got=%b/%0d exp=1/3", irq, irq_id);
    end
    rd(8'h0C, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL edge_claim got=%0d exp=3", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_drop got=%b exp=0", irq); end
    rd(8'h00, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL edge_pend got=%h exp=0", d); end
    src[2] = 1'b0;
    wr(8'h0C, 32'd3);
    idle(3);
  endtask

  task automatic test_two_edges();
    logic [31:0] d;
    src[1] = 1'b1; src[3] = 1'b1;
    idle(3);
    src[1] = 1'b0; src[3] = 1'b0;
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd2) begin
      bad++; $display("FAIL two_sel got=%b/%0d exp=1/2", irq, irq_id);
    end
    rd(8'h0C, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL two_claim got=%0d exp=2", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL two_busy_irq got=%b exp=0", irq); end
    rd(8'h0C, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL two_busy_claim got=%0d exp=0", d); end
    wr(8'h0C, 32'd2);
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd4) begin
      bad++; $display("FAIL two_next got=%b/%0d exp=1/4", irq, irq_id);
    end
    rd(8'h0C, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL two_claim4 got=%0d exp=4", d); end
    wr(8'h0C, 32'd4);
    idle(3);
  endtask

  task automatic test_level();
    logic [31:0] d;
    wr(8'h08, 32'h0);
    wr(8'h04, 32'h1);
    src[0] = 1'b1;
    idle(3);
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd1) begin
      bad++; $display("FAIL lvl_req got=%b/%0d exp=1/1", irq, irq_id);
    end
    rd(8'h0C, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL lvl_claim got=%0d exp=1", d); end
    rd(8'h00, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL lvl_pend_clr got=%h exp=0", d); end
    wr(8'h0C, 32'd2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_wrong_cmpl got=%b exp=0", irq); end
    wr(8'h0C, 32'd1);
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd1) begin
      bad++; $display("FAIL lvl_retrig got=%b/%0d exp=1/1", irq, irq_id);
    end
    rd(8'h00, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL lvl_pend_set got=%h exp=1", d); end
    src[0] = 1'b0;
    idle(3);
    rd(8'h0C, d);
    wr(8'h0C, 32'd1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_quiet got=%b exp=0", irq); end
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    wr(8'h08, 32'hF);
    wr(8'h04, 32'h0);
    src[1] = 1'b1;
    idle(3);
    src[1] = 1'b0;
    rd(8'h00, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL dis_pend got=%h exp=2", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL dis_irq got=%b exp=0", irq); end
    wr(8'h04, 32'h2);
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd2) begin
      bad++; $display("FAIL dis_reen got=%b/%0d exp=1/2", irq, irq_id);
    end
    idle(3);
    // New rising edge lands in the claim cycle.
    src[1] = 1'b1;
    tick(); tick();
    rd(8'h0C, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL race_claim got=%0d exp=2", d); end
    rd(8'h00, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL race_pend got=%h exp=2", d); end
    wr(8'h0C, 32'd2);
    total++;
    if (irq !== 1'b1 || irq_id !== 3'd2) begin
      bad++; $display("FAIL race_next got=%b/%0d exp=1/2", irq, irq_id);
    end
    rd(8'h0C, d);
    wr(8'h0C, 32'd2);
    src[1] = 1'b0;
    idle(3);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(8'h04, 32'hF);
    src[3] = 1'b1; src[2] = 1'b1;
    idle(3);
    rd(8'h0C, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL mid_claim got=%0d exp=3", d); end
    rst_n = 1'b0;
    src = '0;
    model_reset();
    #1;
    total++;
    if (irq !== 1'b0 || irq_id !== '0) begin
      bad++; $display("FAIL mid_rst_irq got=%b/%0d exp=0/0", irq, irq_id);
    end
    req = 1'b1; we = 1'b0; addr = 8'h00;
    #1;
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL mid_rst_pend got=%h exp=0", rdata); end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(8'h0C, 32'd3);
    rd(8'h0C, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_after got=%0d exp=0", d); end
    rd(8'h04, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_enable got=%h exp=0", d); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) src = src ^ MUN'(1 << $urandom_range(0, MUN - 1));
      req = 1'b0; we = 1'b0;
      addr = {4'($urandom()), 2'($urandom_range(0, 3)), 2'($urandom())};
      wdata = $urandom();
      if (r < 40) begin
        req = 1'b1;
      end else if (r < 65) begin
        req = 1'b1; we = 1'b1;
        if (addr[3:2] == 2'd3 && $urandom_range(0, 1) == 1) wdata[IDW-1:0] = m_isid;
      end
      #1;
      total++;
      if (rdata !== m_rdata()) begin
        bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata, m_rdata());
      end
      tick();
      total++;
      if (irq !== m_irq() || irq_id !== m_id()) begin
        bad++;
        $display("FAIL rnd_irq n=%0d got=%b/%0d exp=%b/%0d", n, irq, irq_id, m_irq(), m_id());
      end
    end
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_edge_basic();
    test_two_edges();
    test_level();
    test_disabled();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
